// File: rtl/lifo_arb_pkg.sv
// Purpose : shared op encodings, arbiter FSM states and width helper for lifo_arbiter.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
package lifo_arb_pkg;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    typedef enum logic {
        ST_ARB,
        ST_LOCKED
    } arb_state_t;

    // Index width that stays at least one bit for a single-entry vector.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lifo_arbiter_rr_arbiter.sv
// Purpose : combinational round-robin picker, first set req bit at or above ptr (wrapping).
// Latency : 0 cycles, pure combinational.
// Backpr. : none; gnt is simply empty when no req bit is set.
// Ports   : req[N] candidates, ptr start index, gnt one-hot grant, gnt_idx its index.
module rr_arbiter
    import lifo_arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = id_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] masked;
    logic           found;

    // Doubling the request vector turns the wrap-around scan into a plain
    // lowest-set-bit search above ptr.
    always_comb begin
        dbl     = {req, req};
        masked  = dbl & ({(2*N){1'b1}} << ptr);
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int j = 0; j < 2*N; j++) begin
            if (!found && masked[j]) begin
                found      = 1'b1;
                gnt_idx    = IW'(j % N);
                gnt        = '0;
                gnt[j % N] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lifo_arbiter.sv
// Purpose : shares one LIFO among NUM_REQ requesters with round-robin grant and optional lock bursts.
// Latency : grant/strobes combinational in the request cycle; pop response RD_LATENCY cycles later.
// Backpr. : req_ready withheld from pushers while full, poppers while empty, and non-owners while locked.
// Ports   : clk/rst (sync active-low); req_valid/op/lock/data and req_ready per requester;
//           rsp_valid/id/data pop return; lifo_data_wr/wr_en/rd_en/data_rd/full/empty to the LIFO.
module lifo_arbiter
    import lifo_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int RD_LATENCY = 1,
    parameter  int LOCK_MAX   = 8,
    localparam int IDW        = id_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_op,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          rsp_valid,
    output logic [IDW-1:0]                rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [DATA_WIDTH-1:0]         lifo_data_wr,
    output logic                          lifo_wr_en,
    output logic                          lifo_rd_en,
    input  logic [DATA_WIDTH-1:0]         lifo_data_rd,
    input  logic                          lifo_full,
    input  logic                          lifo_empty
);

    localparam int CW = $clog2(LOCK_MAX + 1);

    arb_state_t             state, state_n;
    logic [IDW-1:0]         rr_ptr, rr_ptr_n;
    logic [IDW-1:0]         owner, owner_n;
    logic [CW-1:0]          lock_cnt, lock_cnt_n;
    logic [NUM_REQ-1:0]     elig, cand, gnt;
    logic [IDW-1:0]         gnt_idx;
    logic                   hs;
    logic [RD_LATENCY-1:0]  pipe_vld;
    logic [IDW-1:0]         pipe_id [RD_LATENCY];

    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    // While locked only the owner can be picked; rr_ptr is irrelevant then.
    always_comb begin
        elig = '0;
        cand = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req_valid[i] & ((req_op[i] == OP_POP) ? !lifo_empty : !lifo_full);
            cand[i] = elig[i] & ((state == ST_ARB) || (int'(owner) == i));
        end
    end

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req     (cand),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // gnt only covers valid requesters, so any grant outside reset is a handshake.
    always_comb begin
        hs           = rst & (|gnt);
        req_ready    = rst ? gnt : '0;
        lifo_wr_en   = hs & (req_op[gnt_idx] == OP_PUSH);
        lifo_rd_en   = hs & (req_op[gnt_idx] == OP_POP);
        lifo_data_wr = lifo_wr_en ? req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;
        // Gated by rst so an in-flight pop never surfaces during reset.
        rsp_valid    = rst & pipe_vld[RD_LATENCY-1];
        rsp_id       = rsp_valid ? pipe_id[RD_LATENCY-1] : '0;
        rsp_data     = rsp_valid ? lifo_data_rd : '0;
    end

    always_comb begin
        state_n    = state;
        rr_ptr_n   = rr_ptr;
        owner_n    = owner;
        lock_cnt_n = lock_cnt;
        unique case (state)
            ST_ARB: begin
                if (hs) begin
                    // With LOCK_MAX==1 the locking handshake is already the last one.
                    if (req_lock[gnt_idx] && (LOCK_MAX > 1)) begin
                        state_n    = ST_LOCKED;
                        owner_n    = gnt_idx;
                        lock_cnt_n = CW'(1);
                    end else begin
                        rr_ptr_n = next_idx(gnt_idx);
                    end
                end
            end
            ST_LOCKED: begin
                if (!req_valid[owner] ||
                    (hs && (!req_lock[owner] || (lock_cnt + CW'(1) == CW'(LOCK_MAX))))) begin
                    state_n    = ST_ARB;
                    lock_cnt_n = '0;
                    rr_ptr_n   = next_idx(owner);
                end else if (hs) begin
                    lock_cnt_n = lock_cnt + CW'(1);
                end
            end
            default: state_n = ST_ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_ARB;
            rr_ptr   <= '0;
            owner    <= '0;
            lock_cnt <= '0;
            pipe_vld <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_id[i] <= '0;
            end
        end else begin
            assert (!(lifo_full && lifo_empty));
            state       <= state_n;
            rr_ptr      <= rr_ptr_n;
            owner       <= owner_n;
            lock_cnt    <= lock_cnt_n;
            pipe_vld[0] <= lifo_rd_en;
            pipe_id[0]  <= gnt_idx;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_id[i]  <= pipe_id[i-1];
            end
        end
    end

endmodule

// File: tb/tb_lifo_arbiter.sv
module tb_lifo_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_op, req_lock, req_ready;
    logic [31:0] req_data;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data, lifo_data_wr, lifo_data_rd;
    logic        lifo_wr_en, lifo_rd_en, lifo_full, lifo_empty;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lifo_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .RD_LATENCY(1), .LOCK_MAX(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_op       (req_op),
        .req_lock     (req_lock),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_id       (rsp_id),
        .rsp_data     (rsp_data),
        .lifo_data_wr (lifo_data_wr),
        .lifo_wr_en   (lifo_wr_en),
        .lifo_rd_en   (lifo_rd_en),
        .lifo_data_rd (lifo_data_rd),
        .lifo_full    (lifo_full),
        .lifo_empty   (lifo_empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] op, input logic [3:0] lk);
        req_valid = v;
        req_op    = op;
        req_lock  = lk;
    endtask

    // Inputs change just after the falling edge; checks follow 1 time unit later.
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst          = 1'b0;
        lifo_full    = 1'b0;
        lifo_empty   = 1'b1;
        lifo_data_rd = 8'h00;
        req_data     = 32'h131211A5;
        drive(4'b0001, 4'b0000, 4'b0000);

        // Reset: everything quiet even with an eligible push pending.
        step(); #1;
        chk("rst_ready",   32'(req_ready),    32'h0);
        chk("rst_wr_en",   32'(lifo_wr_en),   32'h0);
        chk("rst_rd_en",   32'(lifo_rd_en),   32'h0);
        chk("rst_data_wr", 32'(lifo_data_wr), 32'h0);
        chk("rst_rsp_vld", 32'(rsp_valid),    32'h0);
        chk("rst_rsp_id",  32'(rsp_id),       32'h0);
        chk("rst_rsp_dat", 32'(rsp_data),     32'h0);

        // 1. push 0xA5 then pop it back.
        step(); rst = 1'b1; #1;
        chk("t1_push_ready", 32'(req_ready),    32'h1);
        chk("t1_push_wr",    32'(lifo_wr_en),   32'h1);
        chk("t1_push_data",  32'(lifo_data_wr), 32'hA5);
        chk("t1_push_rd",    32'(lifo_rd_en),   32'h0);
        step(); lifo_empty = 1'b0; drive(4'b0001, 4'b0001, 4'b0000); #1;
        chk("t1_pop_ready",  32'(req_ready),    32'h1);
        chk("t1_pop_rd",     32'(lifo_rd_en),   32'h1);
        chk("t1_pop_wr",     32'(lifo_wr_en),   32'h0);
        chk("t1_pop_dwr",    32'(lifo_data_wr), 32'h0);
        chk("t1_pop_rspv0",  32'(rsp_valid),    32'h0);
        step(); lifo_empty = 1'b1; lifo_data_rd = 8'hA5; drive(4'b0000, 4'b0000, 4'b0000); #1;
        chk("t1_rsp_valid",  32'(rsp_valid),    32'h1);
        chk("t1_rsp_id",     32'(rsp_id),       32'h0);
        chk("t1_rsp_data",   32'(rsp_data),     32'hA5);
        chk("t1_idle_ready", 32'(req_ready),    32'h0);
        step(); #1;
        chk("t1_rsp_drop",   32'(rsp_valid),    32'h0);
        chk("t1_rsp_dzero",  32'(rsp_data),     32'h0);

        // 2. rr_ptr is 1 here; a lone req3 push wraps it to 0, then all four push.
        req_data = 32'h13121110;
        step(); drive(4'b1000, 4'b0000, 4'b0000); #1;
        chk("t2_req3_ready", 32'(req_ready), 32'h8);
        for (int k = 0; k < 8; k++) begin
            step(); drive(4'b1111, 4'b0000, 4'b0000); #1;
            chk($sformatf("t2_rr_ready_%0d", k), 32'(req_ready),    32'(1 << (k % 4)));
            chk($sformatf("t2_rr_data_%0d", k),  32'(lifo_data_wr), 32'(8'h10 + (k % 4)));
        end

        // 3. Full: pop wins, push waits until full drops.
        step(); lifo_full = 1'b1; lifo_empty = 1'b0; drive(4'b0110, 4'b0100, 4'b0000); #1;
        chk("t3_full_ready", 32'(req_ready),  32'h4);
        chk("t3_full_rd",    32'(lifo_rd_en), 32'h1);
        chk("t3_full_wr",    32'(lifo_wr_en), 32'h0);
        step(); lifo_full = 1'b0; lifo_data_rd = 8'h5C; #1;
        chk("t3_drop_ready", 32'(req_ready),    32'h2);
        chk("t3_drop_data",  32'(lifo_data_wr), 32'h11);
        chk("t3_rsp_id",     32'(rsp_id),       32'h2);
        chk("t3_rsp_data",   32'(rsp_data),     32'h5C);
        step(); drive(4'b0000, 4'b0000, 4'b0000); #1;
        chk("t3_idle_rsp",   32'(rsp_valid),    32'h0);

        // 4. req3 locked pops: 8 grants despite req0 waiting, then release to req0.
        lifo_data_rd = 8'h33;
        for (int k = 1; k <= 8; k++) begin
            step(); drive(4'b1001, 4'b1001, 4'b1000); #1;
            chk($sformatf("t4_lock_ready_%0d", k), 32'(req_ready), 32'h8);
            if (k > 1) chk($sformatf("t4_lock_rsp_%0d", k), 32'(rsp_id), 32'h3);
        end
        step(); #1;
        chk("t4_release_ready", 32'(req_ready), 32'h1);
        chk("t4_release_rsp",   32'(rsp_id),    32'h3);
        step(); #1;
        chk("t4_relock_ready",  32'(req_ready), 32'h8);
        chk("t4_relock_rsp",    32'(rsp_id),    32'h0);
        // Owner drops valid: lock ends, rr_ptr goes to 0.
        step(); drive(4'b0000, 4'b0000, 4'b0000); #1;
        chk("t4_drop_ready",    32'(req_ready), 32'h0);
        step(); drive(4'b0011, 4'b0011, 4'b0000); #1;
        chk("t4_after_drop",    32'(req_ready), 32'h1);
        // Locked owner blocked by full: nobody granted, lock kept.
        step(); drive(4'b0100, 4'b0000, 4'b0100); #1;
        chk("t4_lock2_ready",   32'(req_ready),    32'h4);
        chk("t4_lock2_data",    32'(lifo_data_wr), 32'h12);
        for (int k = 0; k < 2; k++) begin
            step(); lifo_full = 1'b1; drive(4'b0101, 4'b0001, 4'b0100); #1;
            chk($sformatf("t4_blocked_%0d", k), 32'(req_ready), 32'h0);
        end
        step(); lifo_full = 1'b0; drive(4'b0101, 4'b0001, 4'b0000); #1;
        chk("t4_unblock",       32'(req_ready), 32'h4);
        step(); drive(4'b1001, 4'b1001, 4'b0000); #1;
        chk("t4_ptr_after_rel", 32'(req_ready), 32'h8);

        // 5. Reset right after a pop: the response is discarded.
        step(); drive(4'b0010, 4'b0010, 4'b0000); #1;
        chk("t5_pop_ready", 32'(req_ready), 32'h2);
        step(); rst = 1'b0; lifo_data_rd = 8'h77; #1;
        chk("t5_rst_rspv",  32'(rsp_valid),  32'h0);
        chk("t5_rst_rspd",  32'(rsp_data),   32'h0);
        chk("t5_rst_ready", 32'(req_ready),  32'h0);
        chk("t5_rst_rd",    32'(lifo_rd_en), 32'h0);
        step(); #1;
        chk("t5_rst2_rspv", 32'(rsp_valid),  32'h0);
        step(); rst = 1'b1; drive(4'b1111, 4'b1111, 4'b0000); #1;
        chk("t5_first_grant", 32'(req_ready), 32'h1);
        chk("t5_first_rspv",  32'(rsp_valid), 32'h0);

        // 6. Empty: poppers get nothing.
        step(); lifo_empty = 1'b1; #1;
        chk("t6_empty_ready", 32'(req_ready),  32'h0);
        chk("t6_empty_rd",    32'(lifo_rd_en), 32'h0);
        chk("t6_prev_rspv",   32'(rsp_valid),  32'h1);
        chk("t6_prev_rspid",  32'(rsp_id),     32'h0);
        step(); #1;
        chk("t6_empty2_ready", 32'(req_ready), 32'h0);
        chk("t6_empty2_rspv",  32'(rsp_valid), 32'h0);
        step(); lifo_empty = 1'b0; drive(4'b1110, 4'b1110, 4'b0000); #1;
        chk("t6_still_arb",    32'(req_ready), 32'h2);

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
